// File: rtl/mi_ram_slave.sv
// Burst memory-interface target answering tester requests from an on-chip RAM.
// An optional LFSR throttle stretches beat timing to stress requester flow control.
module mi_ram_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_AW     = 10,
    parameter int STALL_EN   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mi_addr,
    input  logic [6:0]            mi_len,
    input  logic                  mi_rw,
    input  logic                  mi_valid,
    output logic                  mi_ready,
    input  logic [31:0]           mi_wdata,
    input  logic [3:0]            mi_wmsk,
    output logic                  mi_wack,
    output logic [31:0]           mi_rdata,
    output logic                  mi_rstb,
    output logic [15:0]           stat_bursts
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int DEPTH = 1 << MEM_AW;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1; never reaches all-zero from a non-zero seed.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [MEM_AW-1:0] addr_r;
    logic [MEM_AW-1:0] addr_next_s;
    logic [6:0]        cnt_r;
    logic [6:0]        cnt_next_s;
    logic [7:0]        lfsr_r;
    logic [7:0]        lfsr_next_s;
    logic              go_s;
    logic              go_next_s;
    logic              accept_s;
    logic              wr_beat_s;
    logic              rd_issue_s;
    logic              ready_r;
    logic              wack_r;
    logic              rstb_r;
    logic [31:0]       rdata_r;
    logic [15:0]       bursts_r;
    logic [31:0]       mem_r [DEPTH];
    logic              unused_addr_s;

    assign unused_addr_s = ^mi_addr[ADDR_WIDTH-1:MEM_AW];

    // Beat slot enable for this cycle and, for the registered strobes, the next cycle
    always_comb begin
        lfsr_next_s = lfsr_step(lfsr_r);
        if (STALL_EN != 0) begin
            go_s      = lfsr_r[0];
            go_next_s = lfsr_next_s[0];
        end else begin
            go_s      = 1'b1;
            go_next_s = 1'b1;
        end
    end

    // Next-state, address and beat-counter logic
    always_comb begin
        state_next_s = state_r;
        addr_next_s  = addr_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        wr_beat_s    = 1'b0;
        rd_issue_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mi_valid) begin
                    accept_s     = 1'b1;
                    addr_next_s  = mi_addr[MEM_AW-1:0];
                    cnt_next_s   = mi_len;
                    state_next_s = mi_rw ? ST_READ : ST_WRITE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (go_s) begin
                    wr_beat_s    = 1'b1;
                    addr_next_s  = addr_r + {{(MEM_AW-1){1'b0}}, 1'b1};
                    cnt_next_s   = cnt_r - 7'd1;
                    state_next_s = (cnt_r == 7'd0) ? ST_IDLE : ST_WRITE;
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            ST_READ: begin
                if (go_s) begin
                    rd_issue_s   = 1'b1;
                    addr_next_s  = addr_r + {{(MEM_AW-1){1'b0}}, 1'b1};
                    cnt_next_s   = cnt_r - 7'd1;
                    state_next_s = (cnt_r == 7'd0) ? ST_DRAIN : ST_READ;
                end else begin
                    state_next_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, burst address and remaining-beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            addr_r  <= {MEM_AW{1'b0}};
            cnt_r   <= 7'd0;
        end else begin
            state_r <= state_next_s;
            addr_r  <= addr_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Registered handshake outputs; ready/wack look ahead one cycle so they line up with the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r  <= 1'b1;
            wack_r   <= 1'b0;
            rstb_r   <= 1'b0;
            rdata_r  <= 32'd0;
            bursts_r <= 16'd0;
            lfsr_r   <= 8'h01;
        end else begin
            ready_r <= (state_next_s == ST_IDLE);
            wack_r  <= (state_next_s == ST_WRITE) && go_next_s;
            rstb_r  <= rd_issue_s;
            if (rd_issue_s) begin
                rdata_r <= mem_r[addr_r];
            end
            if (accept_s) begin
                bursts_r <= bursts_r + 16'd1;
            end
            lfsr_r <= lfsr_next_s;
        end
    end

    // RAM byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_beat_s && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (!mi_wmsk[b]) begin
                    mem_r[addr_r][8*b +: 8] <= mi_wdata[8*b +: 8];
                end
            end
        end
    end

    assign mi_ready    = ready_r;
    assign mi_wack     = wack_r;
    assign mi_rstb     = rstb_r;
    assign mi_rdata    = rdata_r;
    assign stat_bursts = bursts_r;

endmodule

// File: tb/tb_mi_ram_slave.sv
// Scoreboard bench: instance 0 runs unthrottled, instance 1 with the LFSR stall enabled.
`timescale 1ns/1ps
module tb_mi_ram_slave;
    localparam int AW = 36;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] mi_addr   [2];
    logic [6:0]    mi_len    [2];
    logic          mi_rw     [2];
    logic          mi_valid  [2];
    logic          mi_ready  [2];
    logic [31:0]   mi_wdata  [2];
    logic [3:0]    mi_wmsk   [2];
    logic          mi_wack   [2];
    logic [31:0]   mi_rdata  [2];
    logic          mi_rstb   [2];
    logic [15:0]   stat_bursts [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mi_ram_slave #(.ADDR_WIDTH(AW), .MEM_AW(10), .STALL_EN(g)) u_dut (
            .clk(clk), .rst(rst),
            .mi_addr(mi_addr[g]), .mi_len(mi_len[g]), .mi_rw(mi_rw[g]),
            .mi_valid(mi_valid[g]), .mi_ready(mi_ready[g]),
            .mi_wdata(mi_wdata[g]), .mi_wmsk(mi_wmsk[g]), .mi_wack(mi_wack[g]),
            .mi_rdata(mi_rdata[g]), .mi_rstb(mi_rstb[g]), .stat_bursts(stat_bursts[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rstb_cnt [2] = '{0, 0};
    int n_bursts [2] = '{0, 0};
    logic [31:0] ref_mem [2][1024];
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    logic [31:0] wd [128];
    logic [3:0]  wm [128];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int g, input logic [31:0] d);
        if (g == 0) exp_q0.push_back(d);
        else        exp_q1.push_back(d);
    endtask

    function automatic logic [31:0] pop_exp(input int g);
        if (g == 0) return exp_q0.pop_front();
        else        return exp_q1.pop_front();
    endfunction

    function automatic int q_size(input int g);
        return (g == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // Reference memory update: word address wraps at 1024, mask bit 1 keeps the old byte
    task automatic ref_write(input int g, input logic [AW-1:0] a, input int len);
        for (int i = 0; i <= len; i++) begin
            int idx;
            idx = (int'(a[9:0]) + i) % 1024;
            for (int b = 0; b < 4; b++) begin
                if (!wm[i][b]) ref_mem[g][idx][8*b +: 8] = wd[i][8*b +: 8];
            end
        end
    endtask

    task automatic wait_accept(input int g, output int acc_cyc);
        int guard;
        bit done;
        guard = 0;
        done = 1'b0;
        acc_cyc = -1;
        while (!done && guard < 5000) begin
            @(negedge clk);
            if (mi_ready[g] === 1'b1) begin
                acc_cyc = cyc;
                done = 1'b1;
                n_bursts[g]++;
            end
            guard++;
        end
        @(posedge clk);
        #1;
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout[%0d]: ready never seen, required within 5000 cycles", g);
        end
    endtask

    task automatic wait_idle(input int g);
        int guard;
        bit done;
        guard = 0;
        done = 1'b0;
        while (!done && guard < 5000) begin
            @(negedge clk);
            if (mi_ready[g] === 1'b1) done = 1'b1;
            guard++;
        end
        @(posedge clk);
        #1;
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL idle_timeout[%0d]: ready stayed low, required within 5000 cycles", g);
        end
    endtask

    task automatic do_write(input int g, input logic [AW-1:0] a, input int len);
        int acc;
        int beat;
        int guard;
        ref_write(g, a, len);
        mi_addr[g] = a; mi_len[g] = 7'(len); mi_rw[g] = 1'b0;
        mi_wdata[g] = wd[0]; mi_wmsk[g] = wm[0]; mi_valid[g] = 1'b1;
        wait_accept(g, acc);
        mi_valid[g] = 1'b0;
        beat = 0;
        guard = 0;
        while (beat <= len && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (mi_wack[g] === 1'b1) begin
                @(posedge clk);
                #1;
                beat++;
                if (beat <= len) begin
                    mi_wdata[g] = wd[beat];
                    mi_wmsk[g]  = wm[beat];
                end
            end
        end
        if (beat <= len) begin
            errors++;
            checks++;
            $display("FAIL wack_timeout[%0d]: beats %0d required %0d", g, beat, len + 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_read(input int g, input logic [AW-1:0] a, input int len);
        int acc;
        for (int i = 0; i <= len; i++) push_exp(g, ref_mem[g][(int'(a[9:0]) + i) % 1024]);
        mi_addr[g] = a; mi_len[g] = 7'(len); mi_rw[g] = 1'b1; mi_valid[g] = 1'b1;
        wait_accept(g, acc);
        mi_valid[g] = 1'b0;
    endtask

    task automatic do_read(input int g, input logic [AW-1:0] a, input int len);
        start_read(g, a, len);
        wait_idle(g);
    endtask

    // Monitor: beat-level model of each target, compared every cycle away from the active edge
    initial begin : monitor
        logic [7:0]  m_lfsr;
        int          wr_left [2];
        int          rd_left [2];
        bit          pend [2];
        logic [15:0] stat_m [2];
        logic [31:0] last_rd [2];
        m_lfsr = 8'h01;
        for (int g = 0; g < 2; g++) begin
            wr_left[g] = 0; rd_left[g] = 0; pend[g] = 1'b0;
            stat_m[g] = 16'd0; last_rd[g] = 32'd0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                logic go;
                logic exp_ready;
                logic exp_wack;
                logic issue;
                go = (g == 0) ? 1'b1 : m_lfsr[0];
                exp_ready = (wr_left[g] == 0) && (rd_left[g] == 0) && !pend[g];
                exp_wack = (wr_left[g] > 0) && go;
                if (mi_rstb[g] === 1'b1) rstb_cnt[g]++;
                if (pend[g]) begin
                    if (q_size(g) == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL rd_underflow[%0d]: scoreboard size 0, required >0", g);
                    end else begin
                        last_rd[g] = pop_exp(g);
                    end
                end
                chk($sformatf("ready[%0d]", g), 64'(mi_ready[g]), 64'(exp_ready));
                chk($sformatf("wack[%0d]", g), 64'(mi_wack[g]), 64'(exp_wack));
                chk($sformatf("rstb[%0d]", g), 64'(mi_rstb[g]), 64'(pend[g]));
                chk($sformatf("rdata[%0d]", g), 64'(mi_rdata[g]), 64'(last_rd[g]));
                chk($sformatf("stat[%0d]", g), 64'(stat_bursts[g]), 64'(stat_m[g]));
                issue = (rd_left[g] > 0) && go;
                if (exp_wack) wr_left[g]--;
                if (issue) rd_left[g]--;
                pend[g] = issue;
                if (rst) begin
                    wr_left[g] = 0; rd_left[g] = 0; pend[g] = 1'b0;
                    stat_m[g] = 16'd0; last_rd[g] = 32'd0;
                    if (g == 0) exp_q0.delete();
                    else        exp_q1.delete();
                end else if (mi_valid[g] && exp_ready) begin
                    if (mi_rw[g]) rd_left[g] = int'(mi_len[g]) + 1;
                    else          wr_left[g] = int'(mi_len[g]) + 1;
                    stat_m[g] = stat_m[g] + 16'd1;
                end
            end
            m_lfsr = rst ? 8'h01 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    initial begin : stim
        int acc;
        int acc2;
        int base;
        int cnt0;
        logic [AW-1:0] a;
        int len;
        for (int g = 0; g < 2; g++) begin
            mi_addr[g] = '0; mi_len[g] = 7'd0; mi_rw[g] = 1'b0; mi_valid[g] = 1'b0;
            mi_wdata[g] = 32'd0; mi_wmsk[g] = 4'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); wm[i] = 4'd0; end
        do_write(0, 36'h10, 3);
        do_read(0, 36'h10, 3);

        wd[0] = 32'hFFFF_FFFF; wm[0] = 4'b0000;
        do_write(0, 36'h20, 0);
        wd[0] = 32'h1234_5678; wm[0] = 4'b0101;
        do_write(0, 36'h20, 0);
        do_read(0, 36'h20, 0);

        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; wm[i] = 4'd0; end
        do_write(0, 36'h3FE, 3);
        do_read(0, 36'h4_0000_03FE, 3);
        do_read(0, 36'h0, 1);

        // Back-to-back: valid stays high, request switches to a read on acceptance
        base = n_bursts[0];
        wd[0] = $urandom; wm[0] = 4'd0;
        ref_write(0, 36'h50, 0);
        mi_addr[0] = 36'h50; mi_len[0] = 7'd0; mi_rw[0] = 1'b0;
        mi_wdata[0] = wd[0]; mi_wmsk[0] = wm[0]; mi_valid[0] = 1'b1;
        wait_accept(0, acc);
        mi_rw[0] = 1'b1;
        push_exp(0, ref_mem[0][16'h50]);
        wait_accept(0, acc2);
        mi_valid[0] = 1'b0;
        chk("b2b_spacing", 64'(acc2 - acc), 64'd2);
        wait_idle(0);
        chk("b2b_stat", 64'(stat_bursts[0]), 64'(base + 2));

        for (int it = 0; it < 6; it++) begin
            a = AW'({$urandom, $urandom});
            len = $urandom_range(0, 20);
            for (int i = 0; i <= len; i++) begin wd[i] = $urandom; wm[i] = 4'd0; end
            do_write(0, a, len);
            for (int i = 0; i <= len; i++) begin wd[i] = $urandom; wm[i] = 4'($urandom_range(0, 15)); end
            do_write(0, a, len);
            do_read(0, {AW'($urandom) & ~36'h3FF} | {26'd0, a[9:0]}, len);
        end

        for (int i = 0; i < 128; i++) begin wd[i] = $urandom; wm[i] = 4'd0; end
        do_write(1, 36'h200, 127);
        cnt0 = rstb_cnt[1];
        do_read(1, 36'h200, 127);
        chk("stall_pulses", 64'(rstb_cnt[1] - cnt0), 64'd128);

        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; wm[i] = 4'd0; end
        do_write(0, 36'h100, 15);
        start_read(0, 36'h100, 15);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_bursts[0] = 0;
        n_bursts[1] = 0;
        chk("rst_stat", 64'(stat_bursts[0]), 64'd0);
        chk("rst_rstb", 64'(mi_rstb[0]), 64'd0);
        chk("rst_ready", 64'(mi_ready[0]), 64'd1);
        do_read(0, 36'h100, 15);

        repeat (5) @(posedge clk);
        #1;
        chk("q0_empty", 64'(exp_q0.size()), 64'd0);
        chk("q1_empty", 64'(exp_q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mi_ram_slave.md
# mi_ram_slave

Memory-interface target that sits directly downstream of the memory tester and answers its burst requests from an on-chip RAM array. It accepts one burst at a time over the `mi_*` request handshake, paces write beats with `mi_wack` and returns read beats with `mi_rstb`. An optional pseudo-random stall generator stretches beat timing to stress the requester's flow control. Used for bring-up and self-test of the tester without external RAM.

## Interface
- `ADDR_WIDTH`, 32: width of `mi_addr`.
- `MEM_AW`, 10: log2 of RAM depth in 32-bit words; only `mi_addr[MEM_AW-1:0]` is used.
- `STALL_EN`, 0: 1 enables LFSR beat throttling.
- `clk`  in  1  sole clock.
- `rst`  in  1  reset; synchronous and active-high.
- `mi_addr`  in  ADDR_WIDTH  burst start word address.
- `mi_len`  in  7  burst length minus one (1..128 beats).
- `mi_rw`  in  1  1 = read, 0 = write.
- `mi_valid`  in  1  request valid.
- `mi_ready`  out  1  request accepted when `mi_valid & mi_ready`.
- `mi_wdata`  in  32  write beat data, sampled on `mi_wack` cycle.
- `mi_wmsk`  in  4  per-byte mask, bit=1 means byte NOT written.
- `mi_wack`  out  1  write beat consumed this cycle.
- `mi_rdata`  out  32  read beat data, valid when `mi_rstb`.
- `mi_rstb`  out  1  read beat strobe.
- `stat_bursts`  out  16  count of accepted bursts, wraps.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE: `mi_ready`=1. On `mi_valid` (accept cycle T): latch addr (low MEM_AW bits), len, rw; beat counter = len; `stat_bursts`+1; go WRITE (rw=0) or READ (rw=1). `mi_ready` is registered: low from T+1.
- Beat slot enable `go` = 1 when STALL_EN=0, else `lfsr[0]`.
- WRITE: each cycle with `go`: `mi_wack`=1, byte lanes with mask bit 0 written at current addr; addr+1; counter-1. On beat with counter==0 → IDLE.
- READ: each cycle with `go`: RAM read issued at current addr, addr+1, counter-1; registered read gives `mi_rdata`/`mi_rstb` next cycle. On last issue → DRAIN. DRAIN: one cycle, emits last `mi_rstb`, → IDLE.
- Address arithmetic modulo 2^MEM_AW: a burst crossing the top wraps to word 0. Upper `mi_addr` bits ignored.
- `mi_len` width 7; counter 7 bits; len=127 gives 128 beats.
- LFSR: 8-bit, taps x^8+x^6+x^5+x^4+1, seed 8'h01 at reset, shifts every cycle regardless of state; never all-zero.
- `mi_valid` held high after acceptance (back-to-back requester) is treated as a new request only once IDLE re-asserts `mi_ready`.
- Requests with `mi_valid` while not ready are ignored (no latching).
- Reset mid-burst: FSM → IDLE, all strobes low immediately next cycle, burst abandoned; RAM contents are NOT cleared.

## Timing
- Reset values: `mi_ready`=1, `mi_wack`=0, `mi_rstb`=0, `mi_rdata`=0, `stat_bursts`=0, LFSR=8'h01.
- Write, N beats, no stall: accept T; `mi_wack` T+1..T+N; `mi_ready`=1 at T+N+1.
- Read, N beats, no stall: issues T+1..T+N; `mi_rstb` T+2..T+N+1; `mi_ready`=1 at T+N+2.
- Write data written to RAM in `mi_wack` cycle; a read accepted afterward returns it (no forwarding needed, minimum gap 1 cycle).
- Min accept-to-accept spacing: N+1 cycles write, N+2 read.
- `mi_rdata` holds last value when `mi_rstb`=0.

## Test plan
- Write 4 beats at addr 0x10, wdata 0xA0..0xA3, wmsk 0 → `mi_wack` exactly 4 consecutive cycles from T+1, `mi_ready` back at T+5; then read len=3 at 0x10 → `mi_rstb` T'+2..T'+5 with 0xA0..0xA3.
- Byte mask: write 0xFFFFFFFF at 0x20, then 0x12345678 with wmsk=4'b0101 → read returns 0x12FF56FF.
- Wrap: MEM_AW=10, write len=3 at 0x3FE → words 0x3FE,0x3FF,0x000,0x001 written; address 0x4000003FE reads same as 0x3FE.
- Back-to-back: `mi_valid` held through write len=0 then read len=0 (request changed on accept) → second accept exactly at T+2, `stat_bursts`=2.
- STALL_EN=1, read len=127 → exactly 128 `mi_rstb` pulses, gaps match LFSR[0]=0 cycles, data in order.
- Assert `rst` for one cycle mid read burst → next cycle `mi_rstb`=0, `mi_ready`=1, `stat_bursts`=0; subsequent read returns previously written data.
